// File: rtl/btn_pkg.sv
// Shared types and default cycle counts for the button conditioner.
// Macro BTN_REPEAT_EN enables the auto-repeat defaults' consumers.
package btn_pkg;
  typedef enum logic [1:0] {
    UP,
    ARM_DOWN,
    DOWN,
    ARM_UP
  } btn_state_t;

  localparam int SYNC_DEFAULT          = 2;
  localparam int DEBOUNCE_DEFAULT      = 250000;
  localparam int REPEAT_DELAY_DEFAULT  = 12500000;
  localparam int REPEAT_PERIOD_DEFAULT = 2500000;
endpackage

// File: rtl/btn_conditioner_if.sv
// Button pins and conditioned outputs bundled for the conditioner.
// Master drives raw pins; slave (the conditioner) drives the outputs.
interface btn_conditioner_if #(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_press_stb;
  logic [N_BTN-1:0] o_release_stb;

  modport master (
    output i_btn,
    input  o_level,
    input  o_press_stb,
    input  o_release_stb
  );

  modport slave (
    input  i_btn,
    output o_level,
    output o_press_stb,
    output o_release_stb
  );
endinterface

// File: rtl/btn_channel.sv
// One button: synchronizer, debounce FSM and counter.
// Auto-repeat counter present only when BTN_REPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef BTN_REPEAT_EN
  ,parameter int REPEAT_DELAY   = REPEAT_DELAY_DEFAULT
  ,parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press_stb,
  output logic o_release_stb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_in;
  btn_state_t             r_state, w_state;
  logic [CW-1:0]          r_cnt, w_cnt;
  logic                   r_level, w_level;
  logic                   r_press, w_press;
  logic                   r_rel, w_rel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{REL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Normalized so 1 always means pressed.
  assign w_in = r_sync[SYNC_STAGES-1] ^ REL;

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep, w_rep;
  logic          r_ph, w_ph;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rep <= '0;
      r_ph  <= 1'b0;
    end else begin
      r_rep <= w_rep;
      r_ph  <= w_ph;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= UP;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_level <= w_level;
      r_press <= w_press;
      r_rel   <= w_rel;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_level = r_level;
    w_press = 1'b0;
    w_rel   = 1'b0;
    unique case (r_state)
      UP: begin
        if (w_in) begin
          w_state = ARM_DOWN;
          w_cnt   = '0;
        end
      end
      ARM_DOWN: begin
        if (!w_in) begin
          w_state = UP;
          w_cnt   = '0;
        end else if (r_cnt == C_LAST) begin
          w_state = DOWN;
          w_cnt   = '0;
          w_level = 1'b1;
          w_press = 1'b1;
        end else if (r_cnt != C_MAX) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DOWN: begin
        if (!w_in) begin
          w_state = ARM_UP;
          w_cnt   = '0;
        end
      end
      ARM_UP: begin
        if (w_in) begin
          w_state = DOWN;
          w_cnt   = '0;
        end else if (r_cnt == C_LAST) begin
          w_state = UP;
          w_cnt   = '0;
          w_level = 1'b0;
          w_rel   = 1'b1;
        end else if (r_cnt != C_MAX) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = UP;
        w_cnt   = '0;
      end
    endcase
`ifdef BTN_REPEAT_EN
    w_rep = r_rep;
    w_ph  = r_ph;
    // Runs only in DOWN, so a bounce through ARM_UP just pauses it.
    if (r_state == DOWN) begin
      if (r_rep == (r_ph ? R_PER : R_DLY)) begin
        w_press = 1'b1;
        w_rep   = '0;
        w_ph    = 1'b1;
      end else begin
        w_rep = r_rep + 1'b1;
      end
    end
    if (w_rel) begin
      w_rep = '0;
      w_ph  = 1'b0;
    end
`endif
  end

  assign o_level       = r_level;
  assign o_press_stb   = r_press;
  assign o_release_stb = r_rel;
endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: reset synchronizer plus channels.
// Define BTN_REPEAT_EN to enable auto-repeat press strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 7,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef BTN_REPEAT_EN
  ,parameter int REPEAT_DELAY   = REPEAT_DELAY_DEFAULT
  ,parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  btn_conditioner_if.slave io_bus
);
  logic [1:0] r_rst_sync;
  logic       w_rst;

  // Assert immediately, release two clocks later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[1];

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
      ,.REPEAT_DELAY   (REPEAT_DELAY)
      ,.REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst         (w_rst),
      .i_btn         (io_bus.i_btn[g]),
      .o_level       (io_bus.o_level[g]),
      .o_press_stb   (io_bus.o_press_stb[g]),
      .o_release_stb (io_bus.o_release_stb[g])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a strobe scoreboard.
// Define BTN_REPEAT_EN to also exercise auto-repeat.
module tb_btn_conditioner;
  localparam int N = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t;

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } ev_t;

  ev_t q[$];

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .ACTIVE_LOW      (1),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
`ifdef BTN_REPEAT_EN
    ,.REPEAT_DELAY   (10)
    ,.REPEAT_PERIOD  (3)
`endif
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int c, logic [N-1:0] p, logic [N-1:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    q.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    check("excl", 32'(bus.o_press_stb & bus.o_release_stb), 0);
    if ((|bus.o_press_stb) || (|bus.o_release_stb) ||
        (q.size() > 0 && q[0].cyc == cyc)) begin
      if (q.size() == 0) begin
        check("unexpected_stb",
              32'({bus.o_press_stb, bus.o_release_stb}), 0);
      end else begin
        e = q.pop_front();
        check("stb_cyc", cyc, e.cyc);
        check("stb_press", 32'(bus.o_press_stb), 32'(e.press));
        check("stb_rel", 32'(bus.o_release_stb), 32'(e.rel));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_btn = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(bus.o_level), 0);
    check("rst_press", 32'(bus.o_press_stb), 0);
    check("rst_rel", 32'(bus.o_release_stb), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    bus.i_btn[0] = 1'b0;
    t = cyc + 7;
    push(t, 7'h01, 7'h00);
    wait_cyc(t - 1);
    check("press_lvl_before", 32'(bus.o_level), 0);
    wait_cyc(t);
    check("press_lvl", 32'(bus.o_level), 32'h01);

    bus.i_btn[0] = 1'b1;
    t = cyc + 7;
    push(t, 7'h00, 7'h01);
    wait_cyc(t);
    check("rel0_lvl", 32'(bus.o_level), 0);
    repeat (4) @(negedge clk);

    bus.i_btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_btn[0] = 1'b1;
    @(negedge clk);
    bus.i_btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_lvl", 32'(bus.o_level), 0);

    bus.i_btn[0] = 1'b0;
    t = cyc + 7;
    push(t, 7'h01, 7'h00);
    wait_cyc(t);
    check("post_bounce_lvl", 32'(bus.o_level), 32'h01);
    repeat (3) @(negedge clk);

    bus.i_btn[0] = 1'b1;
    t = cyc + 7;
    push(t, 7'h00, 7'h01);
    wait_cyc(t - 1);
    check("rel_lvl_before", 32'(bus.o_level), 32'h01);
    wait_cyc(t);
    check("rel_lvl", 32'(bus.o_level), 0);
    repeat (4) @(negedge clk);

    bus.i_btn[0] = 1'b0;
    bus.i_btn[3] = 1'b0;
    t = cyc + 7;
    push(t, 7'h09, 7'h00);
    wait_cyc(t);
    check("sim_lvl", 32'(bus.o_level), 32'h09);
    repeat (3) @(negedge clk);

    bus.i_btn[2] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_lvl", 32'(bus.o_level), 0);
    check("midrst_press", 32'(bus.o_press_stb), 0);
    check("midrst_rel", 32'(bus.o_release_stb), 0);
    repeat (3) @(negedge clk);
    check("inrst_lvl", 32'(bus.o_level), 0);
    rst = 1'b0;
    t = cyc + 9;
    push(t, 7'h0D, 7'h00);
    wait_cyc(t - 1);
    check("postrst_lvl_before", 32'(bus.o_level), 0);
    wait_cyc(t);
    check("postrst_lvl", 32'(bus.o_level), 32'h0D);

    bus.i_btn = '1;
    t = cyc + 7;
    push(t, 7'h00, 7'h0D);
    wait_cyc(t);
    check("all_rel_lvl", 32'(bus.o_level), 0);
    repeat (4) @(negedge clk);

`ifdef BTN_REPEAT_EN
    bus.i_btn[1] = 1'b0;
    t = cyc + 7;
    push(t, 7'h02, 7'h00);
    push(t + 10, 7'h02, 7'h00);
    push(t + 13, 7'h02, 7'h00);
    push(t + 16, 7'h02, 7'h00);
    wait_cyc(t + 14);
    bus.i_btn[1] = 1'b1;
    push(cyc + 7, 7'h00, 7'h02);
    wait_cyc(cyc + 7);
    check("rep_rel_lvl", 32'(bus.o_level), 0);
`endif

    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("final_lvl", 32'(bus.o_level), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel push-button input conditioner. Synchronizes raw board buttons into `i_clk`, rejects contact bounce with a per-channel stability counter, and produces clean levels plus single-cycle press/release strobes. Sits between the board button pins and the consumers of button state: the CPU GPIO input word and the reset-pulse logic.

## Interface
- `N_BTN`, 7: number of button channels.
- `ACTIVE_LOW`, 1: 1 means a raw input of 0 is "pressed".
- `SYNC_STAGES`, 2: synchronizer flop depth, minimum 2.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a change, minimum 1.
- `REPEAT_DELAY`, 12500000: cycles held before the first auto-repeat (used only with `BTN_REPEAT_EN`).
- `REPEAT_PERIOD`, 2500000: cycles between auto-repeats (used only with `BTN_REPEAT_EN`).

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_btn`  in  N_BTN  raw asynchronous button pins.
- `o_level`  out  N_BTN  debounced state, 1 = pressed.
- `o_press_stb`  out  N_BTN  one-cycle pulse on accepted press (and on repeats).
- `o_release_stb`  out  N_BTN  one-cycle pulse on accepted release.

## Operation
- Each channel is fully independent.
- Synchronizer: `SYNC_STAGES` flops. The output is normalized to 1 = pressed, using `ACTIVE_LOW`.
- Per-channel FSM:
  - `UP` -> `ARM_DOWN` when the synced input is 1.
  - `ARM_DOWN`:
    - Counter increments each cycle the synced input is 1.
    - Synced input 0 -> back to `UP`, counter cleared.
    - Count reaches `DEBOUNCE_CYCLES` -> `DOWN`, `o_level`=1, `o_press_stb` pulses, counter cleared.
  - `DOWN` -> `ARM_UP` when the synced input is 0.
  - `ARM_UP`: mirror of `ARM_DOWN`. On completion -> `UP`, `o_level`=0, `o_release_stb` pulses.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
- `DEBOUNCE_CYCLES`=1: the change is accepted on the first edge it is seen; `ARM_*` states are transient.
- Bounce: any reversion of the synced input during `ARM_*` discards the partial count. The accepted level is unchanged.
- Press and release strobes of one channel are never high in the same cycle.
- Different channels may strobe in the same cycle.

## Timing
- Reset values (asynchronous assert):
  - all sync flops at the "released" raw value;
  - FSM `UP`, counters 0;
  - `o_level`, `o_press_stb`, `o_release_stb` all 0.
- Reset deassertion is internally synchronized to `i_clk`, 2 flops.
- A button held through reset is reported as a normal press once it is debounced.
- Latency: a raw edge that then stays stable appears on `o_level` and the strobe exactly `SYNC_STAGES + DEBOUNCE_CYCLES` rising edges after the first sampling edge.
- Strobes are high for exactly one cycle. All outputs are registered.
- Reset mid-count: the count is lost and outputs drop to 0 immediately. No strobe is emitted on reset exit.

## Configuration
- `BTN_REPEAT_EN`
  - Defined: while in `DOWN`, a per-channel repeat counter runs. `o_press_stb` pulses again after `REPEAT_DELAY` cycles held past acceptance, then every `REPEAT_PERIOD` cycles. Leaving `DOWN` (entering `ARM_UP`) freezes the repeat counter; returning to `DOWN` after a bounce resumes it without reset. Acceptance of release clears it.
  - Undefined: one press strobe per accepted press. Repeat counters and parameters are absent and ignored.

## Structure
- Package `btn_pkg`:
  - `btn_state_t` enum (`UP`, `ARM_DOWN`, `DOWN`, `ARM_UP`);
  - default constants for the debounce and repeat cycle counts.
- Sub-module `btn_channel`: synchronizer, FSM, debounce counter and optional repeat counter for one channel. It is instantiated `N_BTN` times in a generate loop.
- Top-level `btn_conditioner` holds only the shared reset synchronizer and the generate loop.

## Test plan
Common settings: `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2, `ACTIVE_LOW`=1.
- Clean press: drive `i_btn[0]` 1->0 and hold. -> `o_press_stb[0]` high for exactly 1 cycle, 6 edges after the first sample; `o_level[0]`=1 thereafter.
- Bounce: `i_btn[0]` low 3 cycles, high 1, low 3, high. -> no strobe and `o_level[0]` stays 0. Then hold low 4+ cycles -> press accepted.
- Release: from pressed, drive high and hold. -> one `o_release_stb[0]` pulse 6 edges later; `o_level[0]`=0. Verify press and release strobes are never simultaneous.
- Simultaneous channels: press channels 0 and 3 on the same edge. -> both strobe in the same cycle; other channels stay 0.
- Reset mid-operation: assert `i_rst` at count 2 with the button held. -> all outputs 0 asynchronously. After release of reset with the button still held -> press strobe at 6 edges after the first post-reset sample (plus the reset-sync delay).
- `BTN_REPEAT_EN` with `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3: hold the press. -> strobes at acceptance, +10, +13, +16 cycles. Release -> repeats stop.
